// File: rtl/lcd_char_render.sv
// Renders one 8x16 ASCII glyph to the LCD: CASET/RASET/RAMWR header, then 128 RGB565 pixels.
// Optional build macro LCD_CHAR_INVERT_EN adds an invert input that swaps FG/BG per character.
module lcd_char_render #(
  parameter int unsigned LCD_W    = 240,
  parameter int unsigned LCD_H    = 320,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst_n,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
`ifdef LCD_CHAR_INVERT_EN
  input  logic        invert,
`endif
  input  logic        wr_done,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_row,
  output logic [8:0]  show_char_data,
  output logic        en_write_show_char,
  output logic        busy,
  output logic        show_char_done
);

  localparam logic [15:0] X_MAX = 16'(LCD_W - 8);
  localparam logic [15:0] Y_MAX = 16'(LCD_H - 16);

  typedef enum logic [2:0] {
    IDLE, HDR_SEND, HDR_WAIT, FETCH, FLAT, PIX_SEND, PIX_WAIT, DONE
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  hdr_idx_r, hdr_idx_nxt_s;
  logic [3:0]  row_r, row_nxt_s;
  logic [2:0]  col_r, col_nxt_s;
  logic        half_r, half_nxt_s;
  logic        latch_s, cap_row_s, send_s;
  logic [8:0]  data_nxt_s, hdr_byte_s;
  logic [15:0] xs_r, ys_r, xe_s, ye_s, x_ext_s, y_ext_s, fg_s, bg_s, color_s;
  logic [6:0]  glyph_r, glyph_s;
  logic [7:0]  row_bits_r;
  logic        pix_bit_s, inv_s;
  logic [8:0]  data_r;
  logic        en_r, busy_r, done_r;
  logic [10:0] font_addr_r;

`ifdef LCD_CHAR_INVERT_EN
  logic invert_r;
  assign inv_s = invert_r;
`else
  assign inv_s = 1'b0;
`endif

  assign x_ext_s = {7'd0, start_x};
  assign y_ext_s = {7'd0, start_y};
  assign glyph_s = (ascii_num >= 7'h20 && ascii_num <= 7'h7E) ? (ascii_num - 7'h20) : 7'h00;
  assign xe_s    = xs_r + 16'd7;
  assign ye_s    = ys_r + 16'd15;
  assign fg_s    = inv_s ? BG_COLOR : FG_COLOR;
  assign bg_s    = inv_s ? FG_COLOR : BG_COLOR;
  assign pix_bit_s = row_bits_r[3'd7 - col_r];
  assign color_s = pix_bit_s ? fg_s : bg_s;

  // Header byte selection by index
  always_comb begin
    hdr_byte_s = {1'b0, 8'h00};
    case (hdr_idx_r)
      4'd0:    hdr_byte_s = {1'b0, 8'h2A};
      4'd1:    hdr_byte_s = {1'b1, xs_r[15:8]};
      4'd2:    hdr_byte_s = {1'b1, xs_r[7:0]};
      4'd3:    hdr_byte_s = {1'b1, xe_s[15:8]};
      4'd4:    hdr_byte_s = {1'b1, xe_s[7:0]};
      4'd5:    hdr_byte_s = {1'b0, 8'h2B};
      4'd6:    hdr_byte_s = {1'b1, ys_r[15:8]};
      4'd7:    hdr_byte_s = {1'b1, ys_r[7:0]};
      4'd8:    hdr_byte_s = {1'b1, ye_s[15:8]};
      4'd9:    hdr_byte_s = {1'b1, ye_s[7:0]};
      4'd10:   hdr_byte_s = {1'b0, 8'h2C};
      default: hdr_byte_s = {1'b0, 8'h00};
    endcase
  end

  // Next-state, counter and strobe logic
  always_comb begin
    state_nxt_s   = state_r;
    hdr_idx_nxt_s = hdr_idx_r;
    row_nxt_s     = row_r;
    col_nxt_s     = col_r;
    half_nxt_s    = half_r;
    latch_s       = 1'b0;
    cap_row_s     = 1'b0;
    send_s        = 1'b0;
    data_nxt_s    = data_r;
    case (state_r)
      IDLE: begin
        if (show_char_flag) begin
          latch_s       = 1'b1;
          hdr_idx_nxt_s = 4'd0;
          row_nxt_s     = 4'd0;
          col_nxt_s     = 3'd0;
          half_nxt_s    = 1'b0;
          state_nxt_s   = HDR_SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR_SEND: begin
        send_s      = 1'b1;
        data_nxt_s  = hdr_byte_s;
        state_nxt_s = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (!wr_done) begin
          state_nxt_s = HDR_WAIT;
        end else if (hdr_idx_r == 4'd10) begin
          state_nxt_s = FETCH;
        end else begin
          hdr_idx_nxt_s = hdr_idx_r + 4'd1;
          state_nxt_s   = HDR_SEND;
        end
      end
      FETCH: state_nxt_s = FLAT;
      FLAT: begin
        cap_row_s   = 1'b1;
        state_nxt_s = PIX_SEND;
      end
      PIX_SEND: begin
        send_s      = 1'b1;
        data_nxt_s  = half_r ? {1'b1, color_s[7:0]} : {1'b1, color_s[15:8]};
        state_nxt_s = PIX_WAIT;
      end
      PIX_WAIT: begin
        if (!wr_done) begin
          state_nxt_s = PIX_WAIT;
        end else if (!half_r) begin
          half_nxt_s  = 1'b1;
          state_nxt_s = PIX_SEND;
        end else if (col_r != 3'd7) begin
          half_nxt_s  = 1'b0;
          col_nxt_s   = col_r + 3'd1;
          state_nxt_s = PIX_SEND;
        end else if (row_r != 4'd15) begin
          half_nxt_s  = 1'b0;
          col_nxt_s   = 3'd0;
          row_nxt_s   = row_r + 4'd1;
          state_nxt_s = FETCH;
        end else begin
          half_nxt_s  = 1'b0;
          col_nxt_s   = 3'd0;
          state_nxt_s = DONE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and sequencing counters
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      hdr_idx_r <= 4'd0;
      row_r     <= 4'd0;
      col_r     <= 3'd0;
      half_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hdr_idx_r <= hdr_idx_nxt_s;
      row_r     <= row_nxt_s;
      col_r     <= col_nxt_s;
      half_r    <= half_nxt_s;
    end
  end

  // Latched request, glyph row buffer and registered outputs
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xs_r        <= 16'd0;
      ys_r        <= 16'd0;
      glyph_r     <= 7'd0;
      row_bits_r  <= 8'd0;
`ifdef LCD_CHAR_INVERT_EN
      invert_r    <= 1'b0;
`endif
      data_r      <= 9'd0;
      en_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      font_addr_r <= 11'd0;
    end else begin
      if (latch_s) begin
        xs_r    <= (x_ext_s > X_MAX) ? X_MAX : x_ext_s;
        ys_r    <= (y_ext_s > Y_MAX) ? Y_MAX : y_ext_s;
        glyph_r <= glyph_s;
`ifdef LCD_CHAR_INVERT_EN
        invert_r <= invert;
`endif
      end
      if (cap_row_s) begin
        row_bits_r <= font_row;
      end
      // Address is presented during FETCH so the ROM word is ready in FLAT
      if (state_nxt_s == FETCH) begin
        font_addr_r <= {glyph_r, row_nxt_s};
      end
      data_r <= data_nxt_s;
      en_r   <= send_s;
      busy_r <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
      done_r <= (state_nxt_s == DONE);
    end
  end

  assign font_addr          = font_addr_r;
  assign show_char_data     = data_r;
  assign en_write_show_char = en_r;
  assign busy               = busy_r;
  assign show_char_done     = done_r;

endmodule
